// File: rtl/reg_bank8x16_pkg.sv
// Shared definitions for the 8x16 register bank: sizes, clear-FSM state
// encoding, the write-port payload and the wrapping increment helper.
package reg_bank8x16_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned ADDR_W   = 3;

    // Clear engine state encoding
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    // One write/increment request as seen at the port
    typedef struct packed {
        logic              wr;
        logic              inc;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    // Increment by one; MSB of the result is the wrap-out carry
    function automatic logic [DATA_W:0] inc_wrap(input logic [DATA_W-1:0] v);
        return {1'b0, v} + (DATA_W+1)'(1);
    endfunction

endpackage

// File: rtl/reg_bank8x16_reg16.sv
// Single DATA_W-bit storage register with synchronous active-low reset and
// load enable.
// Ports: clk, rst_n (sync, active-low), ld (load enable), d (load value),
//        q (stored value).
module reg16
    import reg_bank8x16_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    // Storage: reset wins, then load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_bank8x16.sv
// Bank of eight 16-bit registers feeding the downstream 8-way selector.
// One write/increment port guarded by wr_ready, a sequential bulk-clear
// engine (one register per cycle), per-register dirty flags and a one-cycle
// increment-overflow pulse.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   wr_en, inc_en     write / increment-in-place request for wr_addr
//   wr_addr, wr_data  target register and write data
//   wr_ready          combinational: !busy && !clr_req
//   clr_req           start bulk clear (ignored while busy)
//   busy              clear engine active
//   dirty             bit k set when register k modified since reset/clear
//   ovf               pulse after an increment wrapped 16'hFFFF -> 0
//   out1..out8        registers 0..7, straight from the flops
module reg_bank8x16
    import reg_bank8x16_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic                inc_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                wr_ready,
    input  logic                clr_req,
    output logic                busy,
    output logic [NUM_REGS-1:0] dirty,
    output logic                ovf,
    output logic [DATA_W-1:0]   out1,
    output logic [DATA_W-1:0]   out2,
    output logic [DATA_W-1:0]   out3,
    output logic [DATA_W-1:0]   out4,
    output logic [DATA_W-1:0]   out5,
    output logic [DATA_W-1:0]   out6,
    output logic [DATA_W-1:0]   out7,
    output logic [DATA_W-1:0]   out8
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic [NUM_REGS-1:0] dirty_q, dirty_d;
    logic                ovf_q, ovf_d;

    logic [DATA_W-1:0]   reg_q [NUM_REGS];
    logic [DATA_W-1:0]   reg_d [NUM_REGS];
    logic [NUM_REGS-1:0] reg_ld;

    wr_req_t             req;
    logic                accept;
    logic                do_write;
    logic                do_inc;
    logic [DATA_W-1:0]   old_val;
    logic [DATA_W:0]     inc_val;

    // Port payload and handshake
    assign req      = '{wr: wr_en, inc: inc_en, addr: wr_addr, data: wr_data};
    assign wr_ready = !busy_q && !clr_req;
    assign accept   = wr_ready && (req.wr || req.inc);

    // Write has priority over increment
    assign do_write = accept && req.wr;
    assign do_inc   = accept && !req.wr && req.inc;

    // Increment source and wrapped result
    assign old_val  = reg_q[req.addr];
    assign inc_val  = inc_wrap(old_val);

    // Per-register load demux: clear sweep or accepted port operation
    always_comb begin
        reg_ld = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            reg_d[k] = '0;
            if (state_q == ST_CLEAR && cnt_q == ADDR_W'(k)) begin
                reg_ld[k] = 1'b1;
                reg_d[k]  = '0;
            end else if ((do_write || do_inc) && req.addr == ADDR_W'(k)) begin
                reg_ld[k] = 1'b1;
                reg_d[k]  = do_write ? req.data : inc_val[DATA_W-1:0];
            end
        end
    end

    // Register storage
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        reg16 u_reg (
            .clk   (clk),
            .rst_n (rst_n),
            .ld    (reg_ld[g]),
            .d     (reg_d[g]),
            .q     (reg_q[g])
        );
    end

    // Clear FSM, dirty and ovf next-state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        dirty_d = dirty_q;
        ovf_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_CLEAR: begin
                dirty_d[cnt_q] = 1'b0;
                cnt_d          = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase

        // Port operations only happen in IDLE, so they never race the sweep
        if (do_write || do_inc) begin
            dirty_d[req.addr] = 1'b1;
        end
        if (do_inc && inc_val[DATA_W]) begin
            ovf_d = 1'b1;
        end
    end

    // Control state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            dirty_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            dirty_q <= dirty_d;
            ovf_q   <= ovf_d;
        end
    end

    // Outputs
    assign busy  = busy_q;
    assign dirty = dirty_q;
    assign ovf   = ovf_q;
    assign out1  = reg_q[0];
    assign out2  = reg_q[1];
    assign out3  = reg_q[2];
    assign out4  = reg_q[3];
    assign out5  = reg_q[4];
    assign out6  = reg_q[5];
    assign out7  = reg_q[6];
    assign out8  = reg_q[7];

endmodule

// File: tb/tb_reg_bank8x16.sv
// Self-checking bench for reg_bank8x16: directed steps followed by random
// traffic, compared against a cycle-level behavioural model of the bank.
module tb_reg_bank8x16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic        inc_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic        clr_req;
    logic        busy;
    logic [7:0]  dirty;
    logic        ovf;
    logic [15:0] out1, out2, out3, out4, out5, out6, out7, out8;
    logic [15:0] outs [8];

    int errors = 0;
    int checks = 0;

    // Behavioural model of the bank
    logic [15:0] m_reg [8];
    logic [7:0]  m_dirty;
    bit          m_busy;
    int          m_idx;
    bit          m_ovf;
    bit          m_valid = 1'b0;

    always #5 clk = ~clk;

    reg_bank8x16 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .inc_en   (inc_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .clr_req  (clr_req),
        .busy     (busy),
        .dirty    (dirty),
        .ovf      (ovf),
        .out1     (out1),
        .out2     (out2),
        .out3     (out3),
        .out4     (out4),
        .out5     (out5),
        .out6     (out6),
        .out7     (out7),
        .out8     (out8)
    );

    assign outs[0] = out1;
    assign outs[1] = out2;
    assign outs[2] = out3;
    assign outs[3] = out4;
    assign outs[4] = out5;
    assign outs[5] = out6;
    assign outs[6] = out7;
    assign outs[7] = out8;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one edge's worth of stimulus (from a negedge), advance the model,
    // and compare every output just after the rising edge.
    task automatic tick(input logic rn, input logic cr, input logic we, input logic ie,
                        input logic [2:0] a, input logic [15:0] d);
        rst_n   = rn;
        clr_req = cr;
        wr_en   = we;
        inc_en  = ie;
        wr_addr = a;
        wr_data = d;
        #1;
        if (m_valid) chk("wr_ready", 32'(wr_ready), 32'(!m_busy && !cr));
        @(posedge clk);
        if (!rn) begin
            for (int k = 0; k < 8; k++) m_reg[k] = 16'h0000;
            m_dirty = 8'h00;
            m_busy  = 1'b0;
            m_idx   = 0;
            m_ovf   = 1'b0;
            m_valid = 1'b1;
        end else begin
            m_ovf = 1'b0;
            if (m_busy) begin
                m_reg[m_idx]   = 16'h0000;
                m_dirty[m_idx] = 1'b0;
                if (m_idx == 7) m_busy = 1'b0;
                m_idx = m_idx + 1;
            end else if (cr) begin
                m_busy = 1'b1;
                m_idx  = 0;
            end else if (we) begin
                m_reg[a]   = d;
                m_dirty[a] = 1'b1;
            end else if (ie) begin
                if (m_reg[a] == 16'hFFFF) m_ovf = 1'b1;
                m_reg[a]   = m_reg[a] + 16'd1;
                m_dirty[a] = 1'b1;
            end
        end
        #1;
        if (m_valid) begin
            for (int k = 0; k < 8; k++) chk($sformatf("out%0d", k + 1), 32'(outs[k]), 32'(m_reg[k]));
            chk("dirty", 32'(dirty), 32'(m_dirty));
            chk("busy",  32'(busy),  32'(m_busy));
            chk("ovf",   32'(ovf),   32'(m_ovf));
        end
        @(negedge clk);
    endtask

    task automatic idle();
        tick(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nb;
        logic [15:0] rd;
        @(negedge clk);

        // Reset then idle
        tick(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
        idle();
        chk("rst_dirty", 32'(dirty), 32'h00);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ready", 32'(wr_ready), 32'h1);
        chk("rst_out8", 32'(out8), 32'h0);

        // Write then increment
        tick(1'b1, 1'b0, 1'b1, 1'b0, 3'd5, 16'hBEEF);
        chk("wr_out6", 32'(out6), 32'hBEEF);
        chk("wr_dirty", 32'(dirty), 32'h20);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 16'h0000);
        chk("inc_out6", 32'(out6), 32'hBEF0);

        // Increment wrap
        tick(1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 16'hFFFF);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 16'h0000);
        chk("wrap_out3", 32'(out3), 32'h0);
        chk("wrap_ovf", 32'(ovf), 32'h1);
        chk("wrap_dirty2", 32'(dirty[2]), 32'h1);
        idle();
        chk("wrap_ovf_drop", 32'(ovf), 32'h0);

        // Write beats increment
        tick(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0009);
        tick(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 16'h0005);
        chk("prio_out1", 32'(out1), 32'h0005);
        chk("prio_ovf", 32'(ovf), 32'h0);

        // Bulk clear with ignored write and ignored second clear
        for (int k = 1; k <= 8; k++) tick(1'b1, 1'b0, 1'b1, 1'b0, 3'(k - 1), 16'(16'h1111 * k));
        tick(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000);
        nb = 0;
        for (int i = 0; i < 20 && busy === 1'b1; i++) begin
            nb++;
            chk("clr_ready", 32'(wr_ready), 32'h0);
            if (i == 2)      tick(1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 16'hDEAD);
            else if (i == 3) tick(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000);
            else             idle();
            if (i == 0) begin
                chk("clr_first_out1", 32'(out1), 32'h0);
                chk("clr_first_out8", 32'(out8), 32'h8888);
            end
        end
        chk("busy_cycles", 32'(nb), 32'd8);
        chk("clr_dirty", 32'(dirty), 32'h00);
        chk("clr_out4", 32'(out4), 32'h0);
        idle();
        chk("clr_no_requeue", 32'(busy), 32'h0);

        // Reset in the middle of a clear
        for (int k = 0; k < 8; k++) tick(1'b1, 1'b0, 1'b1, 1'b0, 3'(k), 16'hA000 + 16'(k));
        tick(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000);
        idle();
        idle();
        tick(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_out8", 32'(out8), 32'h0);
        tick(1'b1, 1'b0, 1'b1, 1'b0, 3'd7, 16'h00A5);
        chk("post_rst_out8", 32'(out8), 32'h00A5);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            int r;
            r  = int'($urandom_range(0, 99));
            rd = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            tick(1'(r != 0), 1'(r < 5), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
